// File: rtl/mem_load_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mem_load_ctrl
//  Purpose  : Streams a LEN-word burst from a valid/ready source into a
//             synchronous-write memory port and drives the load_mem/done pair
//             seen by the load-completion monitor. Raises sticky err_late when
//             done arrives more than MAX_LAT cycles after rose(load_mem).
//  Options  : MEM_LOAD_ABORT_EN adds the abort input and sticky aborted output.
//  Revision : 1.0  initial release
// ============================================================================
module mem_load_ctrl #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 4,
   parameter int MAX_LAT = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   input  logic              src_valid,
   input  logic [DATA_W-1:0] src_data,
   output logic              src_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              load_mem,
   output logic              done,
   output logic              busy,
`ifdef MEM_LOAD_ABORT_EN
   input  logic              abort,
   output logic              aborted,
`endif
   output logic              err_late
);

   // Latency counter must be able to hold MAX_LAT+1 so a late done is visible.
   localparam int LAT_W = $clog2(MAX_LAT + 2);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [ADDR_W:0]  C_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [LAT_W-1:0] C_LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};
   localparam logic [LAT_W-1:0] C_LAT_SAT = {LAT_W{1'b1}};
   localparam logic [LAT_W-1:0] C_MAX_LAT = LAT_W'(MAX_LAT);

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W:0]   r_len;
   logic [ADDR_W:0]   r_word_cnt;
   logic [LAT_W-1:0]  r_lat_cnt;
   logic              r_err_late;
   logic              w_accept;
   logic              w_last;
   logic              w_abort;

`ifdef MEM_LOAD_ABORT_EN
   logic              r_aborted;
   assign w_abort = abort;
   assign aborted = r_aborted;
`else
   assign w_abort = 1'b0;
`endif

   // A start is only honoured in IDLE and only for a non-zero length.
   assign w_accept = (r_state == S_IDLE) && start && (len != '0);
   assign w_last   = (r_word_cnt == (r_len - C_CNT_ONE));
   assign err_late = r_err_late;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; abort outranks the final write
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_LOAD;
         S_LOAD: begin
            if (w_abort) begin
               w_state_nxt = S_DONE;
            end else if (mem_we && w_last) begin
               w_state_nxt = S_DONE;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode; memory port is combinational from the source handshake
   always_comb begin
      src_ready = (r_state == S_LOAD);
      load_mem  = (r_state == S_LOAD) || (r_state == S_DONE);
      done      = (r_state == S_DONE);
      busy      = (r_state != S_IDLE);
      mem_we    = src_ready && src_valid && !w_abort;
      mem_addr  = r_base + r_word_cnt[ADDR_W-1:0];
      mem_wdata = src_data;
   end

   // Burst bookkeeping: captured command, word/latency counters, sticky flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base     <= '0;
         r_len      <= '0;
         r_word_cnt <= '0;
         r_lat_cnt  <= '0;
         r_err_late <= 1'b0;
`ifdef MEM_LOAD_ABORT_EN
         r_aborted  <= 1'b0;
`endif
      end else if (w_accept) begin
         r_base     <= base_addr;
         r_len      <= len;
         r_word_cnt <= '0;
         r_lat_cnt  <= '0;
         r_err_late <= 1'b0;
`ifdef MEM_LOAD_ABORT_EN
         r_aborted  <= 1'b0;
`endif
      end else if (r_state == S_LOAD) begin
         if (mem_we) begin
            r_word_cnt <= r_word_cnt + C_CNT_ONE;
         end
         if (r_lat_cnt != C_LAT_SAT) begin
            r_lat_cnt <= r_lat_cnt + C_LAT_ONE;
         end
`ifdef MEM_LOAD_ABORT_EN
         if (w_abort) begin
            r_aborted <= 1'b1;
         end
`endif
      end else if (r_state == S_DONE) begin
         // In DONE the counter equals the rose(load_mem)-to-done distance.
         if (r_lat_cnt > C_MAX_LAT) begin
            r_err_late <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/mem_load_ctrl.md
Name: mem_load_ctrl

Overview:
Memory-load controller that sits directly upstream of the load-completion monitor. It accepts a load command, streams LEN words from a valid/ready source into a simple synchronous-write memory port, and drives the load_mem/done pair that the monitor consumes. The monitor expects rose(load_mem) followed by done within a bounded window; this block also flags its own late completions against that window.

Parameters:
DATA_W, 8, memory word width
ADDR_W, 4, memory address width; a burst may hold up to 2**ADDR_W words
MAX_LAT, 5, cycles allowed from rose(load_mem) to done before err_late is set

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  reset, asynchronous, active-low
start  in  1  load command strobe, sampled in IDLE only
base_addr  in  ADDR_W  first write address, captured on an accepted start
len  in  ADDR_W+1  word count, captured on an accepted start; 0 is illegal
src_valid  in  1  source word valid
src_data  in  DATA_W  source word
src_ready  out  1  block accepts a source word this cycle
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory write address
mem_wdata  out  DATA_W  memory write data
load_mem  out  1  load in progress, toward downstream monitor
done  out  1  one-cycle completion pulse, toward downstream monitor
busy  out  1  state is not IDLE
err_late  out  1  sticky: last done came more than MAX_LAT cycles after rose(load_mem)

Behaviour:
- Reset: the state goes to IDLE and all outputs are 0. This includes load_mem, done, src_ready, mem_we, err_late, and the internal counters.
- The FSM has three states: IDLE, LOAD and DONE.
- IDLE:
  - start=1 with len!=0 is accepted. The block captures base_addr and len, clears word_cnt, lat_cnt and err_late, and moves to LOAD on the next edge.
  - start with len=0 is ignored, with no output change.
- LOAD:
  - load_mem=1 and src_ready=1.
  - mem_we, mem_addr and mem_wdata are combinational: mem_we = src_valid & src_ready, mem_addr = base_addr + word_cnt (mod 2**ADDR_W, so addresses wrap), mem_wdata = src_data.
  - Each write increments word_cnt.
  - On the write where word_cnt = len-1, the FSM moves to DONE.
  - If src_valid is low, the block stalls in LOAD and lat_cnt keeps counting.
- DONE:
  - Lasts exactly one cycle: done=1, load_mem=1, src_ready=0.
  - The next state is IDLE, where load_mem=0.
- Latency counting:
  - lat_cnt is 0 in the first LOAD cycle (the rose(load_mem) cycle) and increments every cycle after that. It saturates at its maximum, and its width must hold MAX_LAT+1.
  - In DONE, if lat_cnt > MAX_LAT, err_late is set on that edge and holds until the next accepted start or reset.
- With no stalls, rose(load_mem)-to-done distance = len cycles, so len <= MAX_LAT never sets err_late.
- start during LOAD or DONE is ignored; no queueing.
- busy = (state != IDLE).
- Asynchronous reset mid-burst returns to IDLE immediately. done is not emitted and no further mem_we occurs.

Optional Feature:
MEM_LOAD_ABORT_EN:
- Enabled: adds input abort (1) and output aborted (1, sticky, cleared on accepted start).
  - abort=1 in LOAD takes priority over a write that cycle: mem_we=0 and the FSM goes to DONE. done still pulses, so the monitor sees completion, and aborted is set.
  - abort in IDLE or DONE is ignored.
- Disabled: neither port exists and the block behaves exactly as specified above.

Test Plan:
- Reset then idle: hold rst_n=0 for 3 cycles, then release with start=0 for 10 cycles -> load_mem, done, mem_we, busy and err_late stay 0.
- Basic burst: base_addr=2, len=3, src_valid held 1 with data A,B,C; start at cycle 0 -> load_mem rises in cycle 1, writes land at addr 2/3/4 in cycles 1-3, done=1 in cycle 4 only, load_mem=0 in cycle 5, err_late=0.
- Late done: len=6 with no stalls -> done 6 cycles after rose(load_mem), err_late=1 after DONE. A following start with len=2 clears err_late and the burst ends with err_late=0.
- Stall plus wrap: base_addr=14, len=4, src_valid low for 2 cycles mid-burst -> addresses 14, 15, 0, 1 in order, mem_we=0 during stall cycles, done 6 cycles after rise, err_late=1.
- Illegal and busy starts: start with len=0 in IDLE -> no activity. start pulsed during LOAD -> ignored, with exactly one done and the burst length unchanged.
- Reset mid-burst: assert rst_n=0 after 2 of 5 writes -> load_mem=0 and mem_we=0 immediately, no done pulse. A later start runs a clean full burst.
- If MEM_LOAD_ABORT_EN is enabled: abort in the 2nd LOAD cycle of a len=5 burst -> one write only, done the next cycle, aborted=1.
